reset_sequencer: RTL and testbench

//  Sequences reset release for the RI5CY secure platform after the clock PLL locks.

---
 rtl/reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Staged reset release for the RI5CY secure platform. After the PLL lock
//   (synchronised) is seen and the debounced button is idle, both resets are
//   held for HOLD_CYCLES. Then peripherals/caches are released, and the core
//   follows STAGGER_CYCLES later. A lock loss, a debounced button press, or an
//   optional watchdog expiry aborts back to WAIT_LOCK and records the cause.
//
// Ports
//   clock           system clock
//   reset           asynchronous, active-high global reset
//   btn_in          raw push-button (active-high, asynchronous)
//   pll_locked      PLL lock indication (asynchronous)
//   wdt_kick        1-cycle watchdog refresh pulse
//   periph_reset_o  active-high reset to caches/peripherals
//   core_reset_o    active-high reset to core
//   seq_state       current state: 0 WAIT_LOCK, 1 HOLD, 2 PERIPH_REL, 3 RUN
//   rst_cause       last abort cause: 00 POR, 01 lock loss, 10 button, 11 watchdog
//
// Configuration
//   RST_SEQ_WDT_EN  when defined, adds the RUN-state watchdog (cause 11).
//                   When undefined, wdt_kick is ignored.
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned DEB_CYCLES     = 250000,
  parameter int unsigned WDT_CYCLES     = 2**24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       pll_locked,
  input  logic       wdt_kick,
  output logic       periph_reset_o,
  output logic       core_reset_o,
  output logic [1:0] seq_state,
  output logic [1:0] rst_cause
);

  localparam logic [1:0] WAIT_LOCK  = 2'd0;
  localparam logic [1:0] HOLD       = 2'd1;
  localparam logic [1:0] PERIPH_REL = 2'd2;
  localparam logic [1:0] RUN        = 2'd3;

  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  localparam int unsigned MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MAX_DW  = (DEB_CYCLES > WDT_CYCLES) ? DEB_CYCLES : WDT_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_HS > MAX_DW) ? MAX_HS : MAX_DW;
  localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

  // Input synchronisers
  logic lock_m, lock_s;
  logic btn_m, btn_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      btn_m  <= btn_in;
      btn_s  <= btn_m;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  logic [CW-1:0] deb_cnt;
  logic          btn_stable;
  logic          btn_prev;
  logic          press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt    <= '0;
      btn_stable <= 1'b0;
      btn_prev   <= 1'b0;
    end else begin
      btn_prev <= btn_stable;
      if (btn_s == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= DEB_LAST) begin
        btn_stable <= btn_s;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
    end
  end

  assign press = btn_stable & ~btn_prev;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    cause_nxt;
  logic [CW-1:0] cnt;
  logic          wdt_expire;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);
  logic [CW-1:0] wdt_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if ((state != RUN) || wdt_kick) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != '1) begin
      wdt_cnt <= wdt_cnt + CW'(1);
    end
  end

  // A kick on the expiry cycle itself still rescues the system.
  assign wdt_expire = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_expire      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cause_nxt = rst_cause;
    if (state == WAIT_LOCK) begin
      if (lock_s && !btn_stable) begin
        state_nxt = HOLD;
      end
    end else if (!lock_s) begin
      state_nxt = WAIT_LOCK;
      cause_nxt = CAUSE_LOCK;
    end else if (wdt_expire) begin
      state_nxt = WAIT_LOCK;
      cause_nxt = CAUSE_WDT;
    end else if (press) begin
      state_nxt = WAIT_LOCK;
      cause_nxt = CAUSE_BTN;
    end else begin
      case (state)
        HOLD:       if (cnt == HOLD_LAST) state_nxt = PERIPH_REL;
        PERIPH_REL: if (cnt == STAG_LAST) state_nxt = RUN;
        default:    ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as seq_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= WAIT_LOCK;
      rst_cause      <= 2'b00;
      periph_reset_o <= 1'b1;
      core_reset_o   <= 1'b1;
      cnt            <= '0;
    end else begin
      state          <= state_nxt;
      rst_cause      <= cause_nxt;
      periph_reset_o <= (state_nxt == WAIT_LOCK) || (state_nxt == HOLD);
      core_reset_o   <= (state_nxt != RUN);
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int unsigned HOLD = 16;
  localparam int unsigned STAG = 4;
  localparam int unsigned DEB  = 8;
  localparam int unsigned WDT  = 32;
  localparam int unsigned SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       lock = 1'b1;
  logic       kick = 1'b0;
  logic       periph;
  logic       core;
  logic [1:0] st;
  logic [1:0] cause;

  reset_sequencer #(
    .HOLD_CYCLES(HOLD),
    .STAGGER_CYCLES(STAG),
    .DEB_CYCLES(DEB),
    .WDT_CYCLES(WDT)
  ) dut (
    .clock(clk),
    .reset(rst),
    .btn_in(btn),
    .pll_locked(lock),
    .wdt_kick(kick),
    .periph_reset_o(periph),
    .core_reset_o(core),
    .seq_state(st),
    .rst_cause(cause)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  st;
    logic        p;
    logic        c;
    logic [1:0]  ca;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Background watchdog refresher
  bit          kick_en = 1'b1;
  int unsigned kick_gap = 20;
  int unsigned since = 0;
  int unsigned last_kick_edge = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (kick_en && since >= kick_gap) begin
        kick = 1'b1;
        since = 1;
        last_kick_edge = cyc + 1;
      end else begin
        kick = 1'b0;
        since++;
      end
    end
  end

  // Monitor: every output change must match the next queued expectation.
  logic [5:0] prev_o;
  logic [5:0] now_o;
  always @(negedge clk) begin
    exp_t e;
    now_o = {st, periph, core, cause};
    if (mon_en) begin
      checks++;
      if (core === 1'b0 && periph === 1'b1) begin
        failures++;
        $display("FAIL core_before_periph cyc=%0d periph=%b core=%b required core=1", cyc, periph, core);
      end
      if (now_o !== prev_o) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got st=%0d p=%b c=%b cause=%0d required no change",
                   cyc, st, periph, core, cause);
        end else begin
          e = q.pop_front();
          if (now_o !== {e.st, e.p, e.c, e.ca} || cyc != e.at) begin
            failures++;
            $display("FAIL transition got st=%0d p=%b c=%b cause=%0d @%0d required st=%0d p=%b c=%b cause=%0d @%0d",
                     st, periph, core, cause, cyc, e.st, e.p, e.c, e.ca, e.at);
          end
        end
      end
    end
    prev_o = now_o;
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input logic [1:0] s, input logic p, input logic c,
                            input logic [1:0] ca, input int unsigned at);
    exp_t e;
    e.st = s; e.p = p; e.c = c; e.ca = ca; e.at = at;
    q.push_back(e);
    cur = e;
  endtask

  // Full release sequence starting with HOLD entry at edge h.
  task automatic seq_from(input int unsigned h, input logic [1:0] ca);
    expect_out(2'd1, 1'b1, 1'b1, ca, h);
    expect_out(2'd2, 1'b0, 1'b1, ca, h + HOLD);
    expect_out(2'd3, 1'b0, 1'b0, ca, h + HOLD + STAG);
  endtask

  task automatic drain(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout pending=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_now(input string name);
    checks++;
    if ({st, periph, core, cause} !== {cur.st, cur.p, cur.c, cur.ca}) begin
      failures++;
      $display("FAIL %s got st=%0d p=%b c=%b cause=%0d required st=%0d p=%b c=%b cause=%0d",
               name, st, periph, core, cause, cur.st, cur.p, cur.c, cur.ca);
    end
  endtask

  initial begin
    int unsigned c0;
    int unsigned r;
    int unsigned k;
    int unsigned w;
    int unsigned plen;

    cur.st = 2'd0; cur.p = 1'b1; cur.c = 1'b1; cur.ca = 2'd0; cur.at = 0;
    step(3);
    mon_en = 1'b1;
    check_now("por_reset_state");

    // Power-on release with lock already present
    rst = 1'b0;
    c0 = cyc;
    seq_from(c0 + SYNC + 1, 2'b00);
    drain("por_sequence", 100);
    check_now("por_run");

    // Lock loss in RUN, then relock
    for (int i = 0; i < 2; i++) begin
      step($urandom_range(5, 40));
      lock = 1'b0;
      c0 = cyc;
      expect_out(2'd0, 1'b1, 1'b1, 2'b01, c0 + SYNC + 1);
      drain("lock_loss", 20);
      check_now("lock_loss_wait");
      step($urandom_range(0, 10));
      lock = 1'b1;
      c0 = cyc;
      seq_from(c0 + SYNC + 1, 2'b01);
      drain("relock", 100);
      check_now("relock_run");
    end

    // Short bounces must not disturb RUN
    for (int i = 0; i < 5; i++) begin
      w = $urandom_range(1, DEB - 1);
      btn = 1'b1;
      step(w);
      btn = 1'b0;
      step($urandom_range(2, 6));
    end
    step(DEB + 4);
    check_now("bounce_ignored");

    // Real press: abort one edge after the debounced level rises
    plen = $urandom_range(12, 24);
    btn = 1'b1;
    c0 = cyc;
    expect_out(2'd0, 1'b1, 1'b1, 2'b10, c0 + SYNC + DEB + 1);
    step(plen);
    check_now("button_held_wait");
    btn = 1'b0;
    r = cyc;
    seq_from(r + SYNC + DEB + 1, 2'b10);
    drain("button_release", 100);
    check_now("button_run");

    // Watchdog
    kick_gap = $urandom_range(2, 30);
    step(100);
    check_now("kicked_stays_run");
    kick_en = 1'b0;
    step(2);
    k = last_kick_edge;
`ifdef RST_SEQ_WDT_EN
    expect_out(2'd0, 1'b1, 1'b1, 2'b11, k + WDT);
    seq_from(k + WDT + 1, 2'b11);
    drain("wdt_expiry", 150);
    kick_en = 1'b1;
    check_now("wdt_rerun");
`else
    step(WDT + 20);
    check_now("no_wdt_stays_run");
    kick_en = 1'b1;
`endif
    kick_gap = 20;
    step(5);

    // Lock loss and debounced press landing on the same edge
    btn = 1'b1;
    c0 = cyc;
    step(DEB);
    lock = 1'b0;
    expect_out(2'd0, 1'b1, 1'b1, 2'b01, c0 + SYNC + DEB + 1);
    step(6);
    btn = 1'b0;
    lock = 1'b1;
    r = cyc;
    seq_from(r + SYNC + DEB + 1, 2'b01);
    drain("simultaneous", 100);
    check_now("simultaneous_run");

    // Async reset in PERIPH_REL
    lock = 1'b0;
    c0 = cyc;
    expect_out(2'd0, 1'b1, 1'b1, 2'b01, c0 + SYNC + 1);
    drain("lock_loss_pre_reset", 20);
    lock = 1'b1;
    c0 = cyc;
    expect_out(2'd1, 1'b1, 1'b1, 2'b01, c0 + SYNC + 1);
    expect_out(2'd2, 1'b0, 1'b1, 2'b01, c0 + SYNC + 1 + HOLD);
    drain("to_periph_rel", 60);
    step($urandom_range(0, 1));
    rst = 1'b1;
    expect_out(2'd0, 1'b1, 1'b1, 2'b00, cyc);
    #1;
    check_now("async_reset_immediate");
    step(2);
    rst = 1'b0;
    c0 = cyc;
    seq_from(c0 + SYNC + 1, 2'b00);
    drain("post_reset_sequence", 100);
    check_now("post_reset_run");

    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout cyc=%0d required completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
